// File: rtl/gun_pkg.sv
// Shared constants and types for the gun position integrator.
// The defaults here feed the parameter defaults of gun_axis and gun_pos_integrator.
package gun_pkg;

  localparam int GUN_POS_W       = 6;
  localparam int GUN_DIV_MAX     = 3;
  localparam int GUN_ACCEL_TICKS = 16;

  // Field widths of the per-axis state in the default configuration.
  localparam int GUN_DIV_W  = $clog2(GUN_DIV_MAX + 1);
  localparam int GUN_HOLD_W = $clog2(GUN_ACCEL_TICKS + 1);

  // Per-axis stepping state (default widths).
  typedef struct packed {
    logic [GUN_DIV_W-1:0]  div;
    logic [GUN_HOLD_W-1:0] hold;
    logic                  dec_q;
    logic                  inc_q;
  } axis_state_t;

endpackage

// File: rtl/gun_axis.sv
// Single-axis divider, hold detector and saturating position register.
// Optional acceleration (step of 2 after a long hold) when GUN_POS_ACCEL_EN is defined.
module gun_axis
  import gun_pkg::*;
#(
  parameter int POS_W       = GUN_POS_W,
  parameter int DIV_MAX     = GUN_DIV_MAX,
  parameter int ACCEL_TICKS = GUN_ACCEL_TICKS,
  parameter int POS_INIT    = 2 ** (POS_W - 1)
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             tick_ev,
  input  logic             btn_dec,
  input  logic             btn_inc,
  input  logic             load_en,
  input  logic [POS_W-1:0] load_pos,
  input  logic             recentre,
  output logic [POS_W-1:0] pos,
  output logic             moving
);

  localparam int               DIV_W      = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [POS_W-1:0] POS_MAX_V  = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] POS_INIT_V = POS_W'(POS_INIT);

  logic             dec_q_r;
  logic             inc_q_r;
  logic [DIV_W-1:0] div_r;
  logic [POS_W-1:0] pos_r;
  logic             moving_r;

  logic             held_s;
  logic [DIV_W-1:0] div_nxt_s;
  logic             step_s;
  logic [POS_W-1:0] step_sz_s;
  logic [POS_W-1:0] pos_step_s;

`ifdef GUN_POS_ACCEL_EN
  localparam int                HOLD_W  = $clog2(ACCEL_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(ACCEL_TICKS);
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] hold_nxt_s;
`endif

  // Hold detection, divider next value, step size and saturated step target.
  always_comb begin
    held_s     = 1'b0;
    div_nxt_s  = {DIV_W{1'b0}};
    step_s     = 1'b0;
    step_sz_s  = POS_W'(1);
    pos_step_s = pos_r;
    // Opposing buttons cancel: no hold, no step.
    if (btn_dec && btn_inc) begin
      held_s = 1'b0;
    end else begin
      held_s = (btn_dec && dec_q_r) || (btn_inc && inc_q_r);
    end
    if (held_s && (div_r < DIV_TC)) begin
      div_nxt_s = div_r + DIV_ONE;
    end else begin
      div_nxt_s = {DIV_W{1'b0}};
    end
    step_s = (div_r == DIV_ONE) && (btn_dec != btn_inc);
`ifdef GUN_POS_ACCEL_EN
    hold_nxt_s = {HOLD_W{1'b0}};
    if (held_s) begin
      if (hold_r < HOLD_TC) begin
        hold_nxt_s = hold_r + HOLD_W'(1);
      end else begin
        hold_nxt_s = hold_r;
      end
    end else begin
      hold_nxt_s = {HOLD_W{1'b0}};
    end
    if (hold_r == HOLD_TC) begin
      step_sz_s = POS_W'(2);
    end else begin
      step_sz_s = POS_W'(1);
    end
`endif
    // Saturate against the headroom so the arithmetic never wraps.
    if (btn_inc) begin
      if (step_sz_s > (POS_MAX_V - pos_r)) begin
        pos_step_s = POS_MAX_V;
      end else begin
        pos_step_s = pos_r + step_sz_s;
      end
    end else begin
      if (step_sz_s > pos_r) begin
        pos_step_s = {POS_W{1'b0}};
      end else begin
        pos_step_s = pos_r - step_sz_s;
      end
    end
  end

  // Axis state: recentre beats load beats stepping; moving pulses only on a real change.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dec_q_r  <= 1'b0;
      inc_q_r  <= 1'b0;
      div_r    <= {DIV_W{1'b0}};
      pos_r    <= POS_INIT_V;
      moving_r <= 1'b0;
`ifdef GUN_POS_ACCEL_EN
      hold_r   <= {HOLD_W{1'b0}};
`endif
    end else begin
      moving_r <= 1'b0;
      if (tick_ev) begin
        dec_q_r <= btn_dec;
        inc_q_r <= btn_inc;
      end
      if (recentre) begin
        pos_r  <= POS_INIT_V;
        div_r  <= {DIV_W{1'b0}};
`ifdef GUN_POS_ACCEL_EN
        hold_r <= {HOLD_W{1'b0}};
`endif
      end else if (load_en) begin
        pos_r  <= load_pos;
        div_r  <= {DIV_W{1'b0}};
`ifdef GUN_POS_ACCEL_EN
        hold_r <= {HOLD_W{1'b0}};
`endif
      end else if (tick_ev) begin
        div_r  <= div_nxt_s;
`ifdef GUN_POS_ACCEL_EN
        hold_r <= hold_nxt_s;
`endif
        if (step_s) begin
          pos_r    <= pos_step_s;
          moving_r <= (pos_step_s != pos_r);
        end
      end
    end
  end

  assign pos    = pos_r;
  assign moving = moving_r;

endmodule

// File: rtl/gun_pos_integrator.sv
// Multi-axis button-driven position integrator (e.g. light-gun cursor).
// Shared tick edge detector plus one gun_axis per channel.
// Define GUN_POS_ACCEL_EN to enable double-speed stepping after a long hold.
module gun_pos_integrator
  import gun_pkg::*;
#(
  parameter int N_AXES      = 2,
  parameter int POS_W       = GUN_POS_W,
  parameter int DIV_MAX     = GUN_DIV_MAX,
  parameter int POS_INIT    = 2 ** (POS_W - 1),
  parameter int ACCEL_TICKS = GUN_ACCEL_TICKS
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic [N_AXES-1:0]       btn_dec,
  input  logic [N_AXES-1:0]       btn_inc,
  input  logic [N_AXES-1:0]       load_en,
  input  logic [N_AXES*POS_W-1:0] load_pos,
  input  logic                    recentre,
  output logic [N_AXES*POS_W-1:0] pos,
  output logic [N_AXES-1:0]       moving
);

  logic tick_q_r;
  logic tick_arm_r;
  logic tick_ev_s;

  // Tick edge detector; arming requires tick seen low, so a tick high at release is not an edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tick_q_r   <= 1'b0;
      tick_arm_r <= 1'b0;
    end else begin
      tick_q_r   <= tick;
      tick_arm_r <= tick_arm_r | ~tick;
    end
  end

  assign tick_ev_s = tick & ~tick_q_r & tick_arm_r;

  for (genvar a = 0; a < N_AXES; a++) begin : g_axis
    gun_axis #(
      .POS_W      (POS_W),
      .DIV_MAX    (DIV_MAX),
      .ACCEL_TICKS(ACCEL_TICKS),
      .POS_INIT   (POS_INIT)
    ) u_axis (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick_ev (tick_ev_s),
      .btn_dec (btn_dec[a]),
      .btn_inc (btn_inc[a]),
      .load_en (load_en[a]),
      .load_pos(load_pos[a*POS_W +: POS_W]),
      .recentre(recentre),
      .pos     (pos[a*POS_W +: POS_W]),
      .moving  (moving[a])
    );
  end

endmodule

// File: tb/tb_gun_pos_integrator.sv
// Scoreboard bench for gun_pos_integrator: expected moving events are queued by the
// stimulus and popped by a monitor whenever the DUT pulses moving.
module tb_gun_pos_integrator;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [1:0]  btn_dec;
  logic [1:0]  btn_inc;
  logic [1:0]  load_en;
  logic [11:0] load_pos;
  logic        recentre;
  logic [11:0] pos;
  logic [1:0]  moving;

  typedef struct packed {
    logic [1:0]  mv;
    logic [11:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  gun_pos_integrator #(
    .N_AXES     (2),
    .POS_W      (6),
    .DIV_MAX    (3),
    .POS_INIT   (32),
    .ACCEL_TICKS(4)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (tick),
    .btn_dec (btn_dec),
    .btn_inc (btn_inc),
    .load_en (load_en),
    .load_pos(load_pos),
    .recentre(recentre),
    .pos     (pos),
    .moving  (moving)
  );

  function automatic logic [11:0] pv(input int p1, input int p0);
    return {6'(p1), 6'(p0)};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse();
    tick = 1'b1;
    cyc(2);
    tick = 1'b0;
    cyc(2);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic expect_move(input logic [1:0] mv, input logic [11:0] p);
    exp_t e;
    e.mv = mv;
    e.p  = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every moving pulse must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && moving !== 2'b00) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_move: moving=%b pos=0x%h, nothing expected", moving, pos);
      end else begin
        mon_e = exp_q.pop_front();
        if (moving !== mon_e.mv || pos !== mon_e.p) begin
          n_fail++;
          $display("FAIL move_event: moving=%b pos=0x%h, required moving=%b pos=0x%h",
                   moving, pos, mon_e.mv, mon_e.p);
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    tick     = 1'b1;
    btn_dec  = 2'b00;
    btn_inc  = 2'b01;
    load_en  = 2'b00;
    load_pos = 12'h000;
    recentre = 1'b0;
    cyc(3);
    // Release with tick already high: must not count as a tick edge.
    reset_n = 1'b1;
    cyc(3);
    check("reset_pos", pos, pv(32, 32));
    check("reset_moving", {10'd0, moving}, 12'h000);
    tick = 1'b0;
    cyc(2);

    // Increment hold from 32: steps on ticks 3, 7 and 11.
    expect_move(2'b01, pv(32, 33));
    expect_move(2'b01, pv(32, 34));
    expect_move(2'b01, pv(32, 35));
    pulses(2);
    check("no_early_step", pos, pv(32, 32));
    pulses(10);
    check("inc_12_ticks", pos, pv(32, 35));

    // Saturation at the top.
    btn_inc = 2'b00;
    pulse();
    load_pos = pv(0, 62);
    load_en  = 2'b01;
    cyc(1);
    load_en  = 2'b00;
    check("load_62", pos, pv(32, 62));
    btn_inc = 2'b01;
    expect_move(2'b01, pv(32, 63));
    pulses(8);
    check("sat_top", pos, pv(32, 63));

    // Both buttons: no stepping, divider cleared.
    btn_inc = 2'b00;
    pulse();
    btn_dec = 2'b01;
    btn_inc = 2'b01;
    pulses(10);
    check("both_hold", pos, pv(32, 63));
    btn_inc = 2'b00;
    expect_move(2'b01, pv(32, 62));
    pulse();
    check("both_clears_div", pos, pv(32, 63));
    pulse();
    check("dec_after_both", pos, pv(32, 62));

    // Priority: recentre over load over step, on the step tick of axis 1.
    btn_dec = 2'b00;
    pulse();
    btn_inc = 2'b10;
    pulses(2);
    tick     = 1'b1;
    load_pos = pv(5, 0);
    load_en  = 2'b10;
    recentre = 1'b1;
    cyc(1);
    load_en  = 2'b00;
    recentre = 1'b0;
    check("recentre_wins", pos, pv(32, 32));
    cyc(1);
    tick = 1'b0;
    cyc(2);
    pulse();
    tick    = 1'b1;
    load_en = 2'b10;
    cyc(1);
    load_en = 2'b00;
    check("load_wins", pos, pv(5, 32));
    cyc(1);
    tick = 1'b0;
    cyc(2);
    btn_inc = 2'b00;
    pulse();

    // Long decrement hold from 10 down to the floor.
    load_pos = pv(0, 10);
    load_en  = 2'b01;
    cyc(1);
    load_en  = 2'b00;
    btn_dec  = 2'b01;
`ifdef GUN_POS_ACCEL_EN
    expect_move(2'b01, pv(5, 9));
    expect_move(2'b01, pv(5, 7));
    expect_move(2'b01, pv(5, 5));
    expect_move(2'b01, pv(5, 3));
    expect_move(2'b01, pv(5, 1));
    expect_move(2'b01, pv(5, 0));
    pulses(27);
    check("accel_floor", pos, pv(5, 0));
`else
    for (int k = 9; k >= 3; k--) expect_move(2'b01, pv(5, k));
    pulses(27);
    check("no_accel_hold", pos, pv(5, 3));
`endif
    btn_dec = 2'b00;
    pulse();

    // Reset mid-hold discards history.
    btn_inc = 2'b01;
    pulses(2);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    pulses(2);
    check("midreset_no_step", pos, pv(32, 32));
    expect_move(2'b01, pv(32, 33));
    pulse();
    check("midreset_step", pos, pv(32, 33));
    btn_inc = 2'b00;
    cyc(4);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected moves never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
